// File: rtl/alu_arb_pkg.sv
// Shared constants and types for the two-requester ALU arbiter.
package alu_arb_pkg;
    localparam int ALU_W = 4;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_RSVD = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_4bit.sv
// 4-bit signed ALU datapath; SLT reports the raw sign of a-b together with its overflow.
module alu_4bit (
    input  logic [2:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] result,
    output logic       zero,
    output logic       overflow
);
    logic [3:0] sum, diff;
    logic       add_ovf, sub_ovf;

    assign sum     = a + b;
    assign diff    = a - b;
    assign add_ovf = (a[3] == b[3]) && (sum[3] != a[3]);
    assign sub_ovf = (a[3] != b[3]) && (diff[3] != a[3]);

    always_comb begin
        result   = 4'b0000;
        overflow = 1'b0;
        case (op)
            3'b000: result = a & b;
            3'b001: result = a | b;
            3'b010: begin result = sum; overflow = add_ovf; end
            3'b011: result = ~(a & b);
            3'b100: result = ~(a | b);
            3'b110: begin result = diff; overflow = sub_ovf; end
            3'b111: begin result = {3'b000, diff[3]}; overflow = sub_ovf; end
            default: result = 4'b0000;
        endcase
    end

    assign zero = (result == 4'b0000);
endmodule

// File: rtl/alu_arb2_ctrl_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the one not granted last.
module rr_arb2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant
);
    assign grant[0] = valid0 & (~valid1 | last_grant);
    assign grant[1] = valid1 & (~valid0 | ~last_grant);
endmodule

// File: rtl/alu_arb2_ctrl.sv
// Arbitrates two request channels onto one alu_4bit, one op in flight (IDLE->EXEC->RESP).
// Optional grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_arb2_ctrl
    import alu_arb_pkg::*;
#(
    parameter int STAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [ALU_W-1:0] req0_a,
    input  logic [ALU_W-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [ALU_W-1:0] req1_a,
    input  logic [ALU_W-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [ALU_W-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_overflow,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [ALU_W-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_overflow,
`ifdef ALU_ARB_STATS_EN
    output logic [STAT_W-1:0] stat_cnt0,
    output logic [STAT_W-1:0] stat_cnt1,
`endif
    output logic             rsp1_err
);
    state_t           state;
    logic             last_grant, cur_id;
    logic [2:0]       op_q;
    logic [ALU_W-1:0] a_q, b_q;
    logic             rsp_vld, rsp_zero, rsp_ovf, rsp_err;
    logic [ALU_W-1:0] rsp_res;
    logic [1:0]       grant;
    logic [ALU_W-1:0] alu_res;
    logic             alu_zero, alu_ovf;
    logic             hs0, hs1;

    rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    alu_4bit u_alu (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .result   (alu_res),
        .zero     (alu_zero),
        .overflow (alu_ovf)
    );

    // Ready is held low while reset is asserted so no handshake can be seen during reset.
    assign req0_ready = (state == IDLE) & ~rst & grant[0];
    assign req1_ready = (state == IDLE) & ~rst & grant[1];
    assign hs0 = req0_valid & req0_ready;
    assign hs1 = req1_valid & req1_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_vld    <= 1'b0;
            rsp_res    <= '0;
            rsp_zero   <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (hs0 | hs1) begin
                    op_q       <= hs1 ? req1_op : req0_op;
                    a_q        <= hs1 ? req1_a  : req0_a;
                    b_q        <= hs1 ? req1_b  : req0_b;
                    cur_id     <= hs1;
                    last_grant <= hs1;
                    state      <= EXEC;
                end
                EXEC: begin
                    rsp_vld <= 1'b1;
                    state   <= RESP;
                    if (op_q == OP_RSVD) begin
                        rsp_res  <= '0;
                        rsp_zero <= 1'b1;
                        rsp_ovf  <= 1'b0;
                        rsp_err  <= 1'b1;
                    end else begin
                        rsp_res  <= alu_res;
                        rsp_zero <= alu_zero;
                        rsp_ovf  <= alu_ovf;
                        rsp_err  <= 1'b0;
                    end
                end
                RESP: if (cur_id ? rsp1_ready : rsp0_ready) begin
                    rsp_vld <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp0_valid    = rsp_vld & ~cur_id;
    assign rsp1_valid    = rsp_vld &  cur_id;
    assign rsp0_result   = rsp_res;
    assign rsp1_result   = rsp_res;
    assign rsp0_zero     = rsp_zero;
    assign rsp1_zero     = rsp_zero;
    assign rsp0_overflow = rsp_ovf;
    assign rsp1_overflow = rsp_ovf;
    assign rsp0_err      = rsp_err;
    assign rsp1_err      = rsp_err;

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else begin
            if (hs0 && stat_cnt0 != '1) stat_cnt0 <= stat_cnt0 + 1'b1;
            if (hs1 && stat_cnt1 != '1) stat_cnt1 <= stat_cnt1 + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_arb2_ctrl.sv
// Self-checking bench: vector table plus scoreboard queue, and hand-built tie/stall/reset sequences.
module tb_alu_arb2_ctrl;
    typedef struct packed {
        logic       id;
        logic [2:0] op;
        logic [3:0] a, b, res;
        logic       z, o, e;
    } vec_t;

    logic       clk = 0, rst = 1;
    logic       req0_valid = 0, req1_valid = 0, rsp0_ready = 1, rsp1_ready = 1;
    logic [2:0] req0_op = 0, req1_op = 0;
    logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [3:0] rsp0_result, rsp1_result;
    logic       rsp0_zero, rsp1_zero, rsp0_overflow, rsp1_overflow, rsp0_err, rsp1_err;
`ifdef ALU_ARB_STATS_EN
    logic [1:0] stat_cnt0, stat_cnt1;
`endif

    int   checks = 0, failures = 0;
    vec_t sb[$];

    always #5 clk = ~clk;

    alu_arb2_ctrl #(.STAT_W(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero), .rsp0_overflow(rsp0_overflow), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero), .rsp1_overflow(rsp1_overflow),
`ifdef ALU_ARB_STATS_EN
        .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1),
`endif
        .rsp1_err(rsp1_err)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic pop_chk(input logic id, input logic [3:0] res, input logic z, input logic o, input logic e);
        vec_t x;
        if (sb.size() == 0) begin
            chk("rsp_unexpected", {7'd0, id}, 8'hff);
        end else begin
            x = sb.pop_front();
            chk("rsp_id", {7'd0, id}, {7'd0, x.id});
            chk("rsp_result", {4'd0, res}, {4'd0, x.res});
            chk("rsp_zero", {7'd0, z}, {7'd0, x.z});
            chk("rsp_overflow", {7'd0, o}, {7'd0, x.o});
            chk("rsp_err", {7'd0, e}, {7'd0, x.e});
        end
    endtask

    // Stimulus changes only at negedge; the monitor looks 2 time units later.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (rsp0_valid && rsp0_ready) pop_chk(1'b0, rsp0_result, rsp0_zero, rsp0_overflow, rsp0_err);
            if (rsp1_valid && rsp1_ready) pop_chk(1'b1, rsp1_result, rsp1_zero, rsp1_overflow, rsp1_err);
        end
    end

    task automatic drive(input vec_t v);
        if (v.id) begin req1_valid = 1; req1_op = v.op; req1_a = v.a; req1_b = v.b; end
        else      begin req0_valid = 1; req0_op = v.op; req0_a = v.a; req0_b = v.b; end
    endtask

    // Called at a negedge; returns at the negedge of handshake cycle + 3.
    task automatic issue(input vec_t v);
        int n = 0;
        drive(v);
        #1;
        while (!(v.id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("grant_timeout", {7'd0, n >= 20}, 8'd0);
        sb.push_back(v);
        @(negedge clk);
        if (v.id) req1_valid = 0; else req0_valid = 0;
        #1;
        chk("exec_rsp0_valid", {7'd0, rsp0_valid}, 8'd0);
        chk("exec_rsp1_valid", {7'd0, rsp1_valid}, 8'd0);
        @(negedge clk); #1;
        chk("lat_rsp_valid", {7'd0, v.id ? rsp1_valid : rsp0_valid}, 8'd1);
        chk("lat_other_valid", {7'd0, v.id ? rsp0_valid : rsp1_valid}, 8'd0);
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[10];
        vec_t e0, e1, s;
        logic grants[4];
        int   g, n;
        tbl[0] = '{0, 3'b010, 4'b0111, 4'b0001, 4'b1000, 0, 1, 0};
        tbl[1] = '{0, 3'b000, 4'b1100, 4'b1010, 4'b1000, 0, 0, 0};
        tbl[2] = '{1, 3'b001, 4'b0101, 4'b0010, 4'b0111, 0, 0, 0};
        tbl[3] = '{1, 3'b011, 4'b1111, 4'b1111, 4'b0000, 1, 0, 0};
        tbl[4] = '{0, 3'b100, 4'b0000, 4'b0000, 4'b1111, 0, 0, 0};
        tbl[5] = '{0, 3'b101, 4'b0011, 4'b0100, 4'b0000, 1, 0, 1};
        tbl[6] = '{0, 3'b111, 4'b0001, 4'b0010, 4'b0001, 0, 0, 0};
        tbl[7] = '{1, 3'b110, 4'b1000, 4'b0001, 4'b0111, 0, 1, 0};
        tbl[8] = '{0, 3'b110, 4'b0101, 4'b0101, 4'b0000, 1, 0, 0};
        tbl[9] = '{1, 3'b010, 4'b0011, 4'b0100, 4'b0111, 0, 0, 0};

        // reset state
        req0_valid = 1; req1_valid = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req0_ready", {7'd0, req0_ready}, 8'd0);
        chk("rst_req1_ready", {7'd0, req1_ready}, 8'd0);
        chk("rst_rsp_valid", {6'd0, rsp1_valid, rsp0_valid}, 8'd0);
        chk("rst_rsp_data", {rsp0_result, rsp0_zero, rsp0_overflow, rsp0_err, 1'b0}, 8'd0);
        req0_valid = 0; req1_valid = 0;
        @(negedge clk); rst = 0;

        foreach (tbl[i]) issue(tbl[i]);

        // both valid every cycle: grants must alternate starting with req0
        e0 = '{0, 3'b110, 4'b1110, 4'b0111, 4'b0111, 0, 1, 0};
        e1 = '{1, 3'b111, 4'b0101, 4'b0001, 4'b0000, 1, 0, 0};
        drive(e0); drive(e1);
        g = 0; n = 0;
        while (g < 4 && n < 40) begin
            #1;
            if (req0_ready && req1_ready) chk("both_ready", 8'd1, 8'd0);
            if (req0_ready) begin sb.push_back(e0); grants[g] = 0; g++; end
            else if (req1_ready) begin sb.push_back(e1); grants[g] = 1; g++; end
            @(negedge clk); n++;
        end
        req0_valid = 0; req1_valid = 0;
        chk("tie_grant_count", g[7:0], 8'd4);
        chk("tie_grant_order", {4'd0, grants[0], grants[1], grants[2], grants[3]}, 8'b0101);
        repeat (3) @(negedge clk);

        // back-pressure on rsp1 with req0 waiting
        rsp1_ready = 0;
        issue('{1, 3'b111, 4'b1101, 4'b0110, 4'b0000, 1, 1, 0});
        s = '{0, 3'b000, 4'b1111, 4'b0011, 4'b0011, 0, 0, 0};
        drive(s);
        repeat (5) begin
            #1;
            chk("stall_rsp1_valid", {7'd0, rsp1_valid}, 8'd1);
            chk("stall_rsp1_data", {rsp1_result, rsp1_zero, rsp1_overflow, rsp1_err, 1'b0}, 8'b0000_1100);
            chk("stall_req_ready", {6'd0, req1_ready, req0_ready}, 8'd0);
            @(negedge clk);
        end
        rsp1_ready = 1;
        @(negedge clk); #1;
        chk("release_idle_req0_ready", {7'd0, req0_ready}, 8'd1);
        sb.push_back(s);
        @(negedge clk); req0_valid = 0;
        repeat (3) @(negedge clk);

        // reset mid-EXEC discards the op; req0 then wins the first tie
        drive('{0, 3'b010, 4'b0001, 4'b0001, 4'b0010, 0, 0, 0});
        #1;
        chk("pre_rst_grant", {7'd0, req0_ready}, 8'd1);
        @(negedge clk); req0_valid = 0;
        #1; rst = 1; #1;
        chk("async_rst_rsp_valid", {6'd0, rsp1_valid, rsp0_valid}, 8'd0);
        @(negedge clk);
        s = '{0, 3'b001, 4'b0001, 4'b0010, 4'b0011, 0, 0, 0};
        drive(s); drive('{1, 3'b000, 4'b0001, 4'b0001, 4'b0001, 0, 0, 0});
        #1;
        chk("in_rst_ready", {6'd0, req1_ready, req0_ready}, 8'd0);
        rst = 0; #1;
        chk("post_rst_tie", {6'd0, req1_ready, req0_ready}, 8'b01);
        sb.push_back(s);
        @(negedge clk); req0_valid = 0; req1_valid = 0;
        repeat (4) @(negedge clk);
        #1;
        chk("post_rst_rsp_valid", {6'd0, rsp1_valid, rsp0_valid}, 8'd0);

`ifdef ALU_ARB_STATS_EN
        @(negedge clk); rst = 1; @(negedge clk); rst = 0;
        repeat (6) issue('{0, 3'b001, 4'b0000, 4'b0001, 4'b0001, 0, 0, 0});
        #1;
        chk("stat_cnt0_sat", {6'd0, stat_cnt0}, 8'd3);
        chk("stat_cnt1", {6'd0, stat_cnt1}, 8'd0);
`endif
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
